// File: rtl/regfile_pkg.sv
// Shared sizing constants for the register file and anything that talks to it.
package regfile_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ADDR_W   = $clog2(NUM_REGS);

    typedef logic [DATA_W-1:0] rf_data_t;
    typedef logic [ADDR_W-1:0] rf_addr_t;

endpackage

// File: rtl/mux_32.sv
// 32:1 word selector used for each register-file read port.
module mux_32 #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NUM    = 32,
    parameter int unsigned SEL_W  = 5
) (
    input  logic [SEL_W-1:0]  sel_i,
    input  logic [DATA_W-1:0] data_i [NUM],
    output logic [DATA_W-1:0] data_o
);

    always_comb begin
        data_o = data_i[sel_i];
    end

endmodule

// File: rtl/register_32.sv
// DATA_W-bit storage register with load enable and synchronous active-high clear.
module register_32 #(
    parameter int unsigned W = 32
) (
    input  logic         clock,
    input  logic         clear_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    // Clear wins over a simultaneous load.
    always_comb begin
        data_d = data_q;
        if (clear_i) begin
            data_d = '0;
        end else if (en_i) begin
            data_d = d_i;
        end
    end

    always_ff @(posedge clock) begin
        data_q <= data_d;
    end

    assign q_o = data_q;

endmodule

// File: rtl/regfile.sv
// Two-read, one-write register file; r0 is hard-wired to zero, reads are
// combinational from current state with no write bypass.
module regfile #(
    parameter int unsigned DATA_W   = regfile_pkg::DATA_W,
    parameter int unsigned NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int unsigned ADDR_W   = regfile_pkg::ADDR_W
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              ctrl_writeEnable,
    input  logic [ADDR_W-1:0] ctrl_writeReg,
    input  logic [DATA_W-1:0] data_writeReg,
    input  logic [ADDR_W-1:0] ctrl_readRegA,
    input  logic [ADDR_W-1:0] ctrl_readRegB,
    output logic [DATA_W-1:0] data_readRegA,
    output logic [DATA_W-1:0] data_readRegB
);

    logic [NUM_REGS-1:0] wr_en_c;
    logic [DATA_W-1:0]   regs [NUM_REGS];

    // One-hot write decode; slot 0 never enabled.
    always_comb begin
        wr_en_c = '0;
        if (ctrl_writeEnable) begin
            wr_en_c[ctrl_writeReg] = 1'b1;
        end
        wr_en_c[0] = 1'b0;
    end

    for (genvar i = 0; i < int'(NUM_REGS); i++) begin : g_reg
        if (i == 0) begin : g_zero
            assign regs[i] = '0;
        end else begin : g_store
            register_32 #(
                .W (DATA_W)
            ) u_reg (
                .clock   (clock),
                .clear_i (ctrl_reset),
                .en_i    (wr_en_c[i]),
                .d_i     (data_writeReg),
                .q_o     (regs[i])
            );
        end
    end

    mux_32 #(
        .DATA_W (DATA_W),
        .NUM    (NUM_REGS),
        .SEL_W  (ADDR_W)
    ) u_mux_a (
        .sel_i  (ctrl_readRegA),
        .data_i (regs),
        .data_o (data_readRegA)
    );

    mux_32 #(
        .DATA_W (DATA_W),
        .NUM    (NUM_REGS),
        .SEL_W  (ADDR_W)
    ) u_mux_b (
        .sel_i  (ctrl_readRegB),
        .data_i (regs),
        .data_o (data_readRegB)
    );

endmodule

// File: tb/tb_regfile.sv
// Bench for regfile: array model checked every cycle plus directed literal checks.
module tb_regfile;
    import regfile_pkg::*;

    logic              clock;
    logic              ctrl_reset;
    logic              ctrl_writeEnable;
    logic [ADDR_W-1:0] ctrl_writeReg;
    logic [DATA_W-1:0] data_writeReg;
    logic [ADDR_W-1:0] ctrl_readRegA;
    logic [ADDR_W-1:0] ctrl_readRegB;
    logic [DATA_W-1:0] data_readRegA;
    logic [DATA_W-1:0] data_readRegB;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] model [NUM_REGS];
    bit                model_valid = 1'b0;

    regfile dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    // Reference behaviour: reset clears everything, otherwise one write to a nonzero index.
    always @(posedge clock) begin
        if (ctrl_reset === 1'b1) begin
            for (int k = 0; k < int'(NUM_REGS); k++) model[k] <= '0;
            model_valid <= 1'b1;
        end else if (ctrl_writeEnable === 1'b1 && ctrl_writeReg != '0) begin
            model[ctrl_writeReg] <= data_writeReg;
        end
    end

    always @(negedge clock) begin
        if (model_valid) begin
            check("model_portA", data_readRegA, model[ctrl_readRegA]);
            check("model_portB", data_readRegB, model[ctrl_readRegB]);
        end
    end

    // Drive one cycle's inputs just after the rising edge.
    task automatic step(input logic rst, input logic we, input int wr,
                        input logic [DATA_W-1:0] wd, input int ra, input int rb);
        @(posedge clock);
        #1;
        ctrl_reset       = rst;
        ctrl_writeEnable = we;
        ctrl_writeReg    = ADDR_W'(wr);
        data_writeReg    = wd;
        ctrl_readRegA    = ADDR_W'(ra);
        ctrl_readRegB    = ADDR_W'(rb);
    endtask

    // Literal check of the read ports in the current cycle, before the next edge.
    task automatic expect_rd(input string name, input logic [DATA_W-1:0] ea,
                             input logic [DATA_W-1:0] eb);
        #1;
        check({name, "_A"}, data_readRegA, ea);
        check({name, "_B"}, data_readRegB, eb);
    endtask

    initial begin
        ctrl_reset       = 1'b1;
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = '0;
        data_writeReg    = '0;
        ctrl_readRegA    = '0;
        ctrl_readRegB    = '0;

        step(1, 0, 0, 32'h0, 0, 0);
        step(1, 1, 4, 32'hCAFEF00D, 3, 17);
        expect_rd("reset_held", 32'h0, 32'h0);
        step(0, 0, 0, 32'h0, 4, 31);
        expect_rd("reset_state", 32'h0, 32'h0);

        step(0, 1, 5, 32'hDEADBEEF, 5, 5);
        expect_rd("r5_before_edge", 32'h0, 32'h0);
        step(0, 0, 0, 32'h0, 5, 5);
        expect_rd("r5_written", 32'hDEADBEEF, 32'hDEADBEEF);

        step(0, 1, 0, 32'hFFFFFFFF, 0, 5);
        step(0, 0, 0, 32'h0, 0, 0);
        expect_rd("r0_discard", 32'h0, 32'h0);

        step(0, 1, 7, 32'h11111111, 0, 0);
        step(0, 1, 7, 32'h22222222, 7, 5);
        expect_rd("r7_no_bypass", 32'h11111111, 32'hDEADBEEF);
        step(0, 0, 0, 32'h0, 7, 7);
        expect_rd("r7_after_edge", 32'h22222222, 32'h22222222);

        step(0, 0, 9, 32'h12345678, 9, 7);
        step(0, 0, 0, 32'h0, 9, 9);
        expect_rd("we0_hold", 32'h0, 32'h0);

        step(0, 1, 31, 32'hA5A5A5A5, 31, 31);
        step(1, 1, 31, 32'h5A5A5A5A, 31, 5);
        expect_rd("r31_before_reset", 32'hA5A5A5A5, 32'hDEADBEEF);
        step(0, 0, 0, 32'h0, 31, 5);
        expect_rd("reset_beats_write", 32'h0, 32'h0);

        for (int i = 1; i < 32; i++) begin
            step(0, 1, i, DATA_W'(i) * 32'h01010101, i, 31 - i);
        end
        for (int i = 0; i < 32; i++) begin
            step(0, 0, 0, 32'h0, i, 31 - i);
            expect_rd("sweep", DATA_W'(i) * 32'h01010101, DATA_W'(31 - i) * 32'h01010101);
        end
        step(0, 0, 0, 32'h0, 31, 1);
        expect_rd("sweep_ends", 32'h1F1F1F1F, 32'h01010101);
        step(0, 1, 12, 32'h0BADC0DE, 12, 0);
        expect_rd("sweep_r12_old", 32'h0C0C0C0C, 32'h0);
        step(0, 0, 0, 32'h0, 12, 13);
        expect_rd("sweep_r12_new", 32'h0BADC0DE, 32'h0D0D0D0D);

        step(0, 0, 0, 32'h0, 0, 0);
        @(posedge clock);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
